l2k_cache_ctrl: RTL and testbench

//  Two-port cache controller for the Limn2600 core: round-robin arbitrates the fetch port (0) and load/store port (1)

---
 rtl/l2k_pkg.sv | 18 +
 rtl/l2k_rr_arb.sv | 33 +++
 rtl/l2k_cache_ctrl.sv | 157 +++++++++++++++
 tb/tb_l2k_cache_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2k_pkg.sv
// Shared state encodings and port ids for the Limn2600 two-port cache controller.
// Imported by l2k_rr_arb and l2k_cache_ctrl.
package l2k_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_MISS   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LDST  = 1'b1;

  function automatic logic gnt_port(input logic [1:0] gnt);
    return gnt[1] ? PORT_LDST : PORT_FETCH;
  endfunction

endpackage

// File: rtl/l2k_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant from req, the last winner
// yields on a tie; history moves only when the grant is taken.
module l2k_rr_arb
  import l2k_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      (req == 2'b11): gnt = (last_grant == PORT_LDST) ? 2'b01 : 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_LDST;
    end else if (advance && (gnt != 2'b00)) begin
      last_grant <= gnt_port(gnt);
    end
  end

endmodule

// File: rtl/l2k_cache_ctrl.sv
// Direct-mapped, word-granular write-through cache controller with fetch/ldst arbitration.
// Optional `L2K_CTRL_STATS_EN adds hit_cnt/miss_cnt lookup counters.
module l2k_cache_ctrl
  import l2k_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              p_valid,
  input  logic [1:0]              p_we,
  input  logic [63:0]             p_addr,
  input  logic [2*DATA_WIDTH-1:0] p_wdata,
  output logic [1:0]              p_ready,
  output logic                    r_valid,
  output logic                    r_id,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
`ifdef L2K_CTRL_STATS_EN
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt,
`endif
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [2:0]             state;
  logic [31:2]            req_addr;
  logic                   req_we;
  logic                   req_id;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic [DATA_WIDTH-1:0]  resp_data;
  logic [NUM_ENTRIES-1:0] valid;

  logic [DATA_WIDTH-1:0] data_mem [NUM_ENTRIES];
  logic [TAG_W-1:0]      tag_mem  [NUM_ENTRIES];

  logic [1:0]            gnt;
  logic                  accept;
  logic                  sel;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  fill;
  logic                  arr_we;
  logic [DATA_WIDTH-1:0] arr_wd;
  logic                  unused_bits;

  assign unused_bits = ^{p_addr[33:32], p_addr[1:0]};

  // Requests are only offered while idle and out of reset.
  l2k_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (p_valid & {2{(state == S_IDLE) && !rst}}),
    .advance (1'b1),
    .gnt     (gnt)
  );

  assign p_ready = gnt;
  assign accept  = (gnt != 2'b00);
  assign sel     = gnt_port(gnt);

  assign idx = req_addr[IDX_W+1:2];
  assign tag = req_addr[31:IDX_W+2];
  assign hit = valid[idx] && (tag_mem[idx] == tag);

  // Write hits update in place; write misses do not allocate.
  assign fill   = (state == S_MISS) && mem_ack;
  assign arr_we = !rst && (fill || ((state == S_LOOKUP) && req_we && hit));
  assign arr_wd = fill ? mem_rdata : req_wdata;

  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_mem[idx] <= arr_wd;
      tag_mem[idx]  <= tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      valid     <= '0;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_id    <= 1'b0;
      req_wdata <= '0;
      resp_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            req_addr  <= sel ? p_addr[63:34] : p_addr[31:2];
            req_we    <= sel ? p_we[1] : p_we[0];
            req_id    <= sel;
            req_wdata <= sel ? p_wdata[DATA_WIDTH +: DATA_WIDTH]
                             : p_wdata[0 +: DATA_WIDTH];
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (req_we) begin
            state <= S_WRITE;
          end else if (hit) begin
            resp_data <= data_mem[idx];
            state     <= S_RESP;
          end else begin
            state <= S_MISS;
          end
        end
        S_MISS: begin
          if (mem_ack) begin
            valid[idx] <= 1'b1;
            resp_data  <= mem_rdata;
            state      <= S_RESP;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            resp_data <= '0;
            state     <= S_RESP;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign r_valid   = (state == S_RESP);
  assign r_id      = r_valid & req_id;
  assign r_data    = r_valid ? resp_data : '0;
  assign mem_req   = (state == S_MISS) || (state == S_WRITE);
  assign mem_we    = (state == S_WRITE);
  assign mem_addr  = mem_req ? {req_addr, 2'b00} : '0;
  assign mem_wdata = mem_we ? req_wdata : '0;

`ifdef L2K_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2k_cache_ctrl.sv
// Bench for l2k_cache_ctrl: directed vector table, arbitration/reset sequences,
// and random traffic against an abstract cache model (stats checked with L2K_CTRL_STATS_EN).
module tb_l2k_cache_ctrl;

  localparam int DW  = 32;
  localparam int NE  = 512;
  localparam int IW  = $clog2(NE);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    p_valid, p_we, p_ready;
  logic [63:0]   p_addr;
  logic [2*DW-1:0] p_wdata;
  logic          r_valid, r_id;
  logic [DW-1:0] r_data;
  logic          mem_req, mem_we, mem_ack;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef L2K_CTRL_STATS_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  l2k_cache_ctrl #(.DATA_WIDTH(DW), .NUM_ENTRIES(NE)) dut (
    .clk       (clk),
    .rst       (rst),
    .p_valid   (p_valid),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_ready   (p_ready),
    .r_valid   (r_valid),
    .r_id      (r_id),
    .r_data    (r_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef L2K_CTRL_STATS_EN
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
`endif
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int cmp = 0;
  int errs = 0;
  int s_hit = 0;
  int s_miss = 0;

  logic [31:0] m_mem [logic [31:0]];
  bit          mv [int];
  logic [31:0] mt [int];
  logic [31:0] md [int];

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    bit          exp_mem;
    bit          exp_hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic rst_dut();
    @(negedge clk);
    rst = 1'b1;
    p_valid = 2'b00;
    p_we = 2'b00;
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mv.delete();
    mt.delete();
    md.delete();
    s_hit = 0;
    s_miss = 0;
  endtask

  // One full transaction on one port, with memory answered after dly wait cycles.
  task automatic txn(input string nm, input bit port, input bit we,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int dly, input bit exp_mem, input logic [31:0] exp_data);
    int rv_k;
    int waitc;
    int exp_k;
    bit saw;
    rv_k = -1;
    waitc = 0;
    saw = 1'b0;
    exp_k = exp_mem ? 3 + dly : 2;
    @(negedge clk);
    p_valid = 2'b00;
    p_valid[port] = 1'b1;
    p_we = 2'b00;
    p_we[port] = we;
    p_addr  = port ? {addr, 32'hFFFF_FFFC} : {32'hFFFF_FFFC, addr};
    p_wdata = port ? {wd, 32'hBAD0_BAD0} : {32'hBAD0_BAD0, wd};
    #1;
    chk({nm, "/p_ready"}, {62'd0, p_ready}, {62'd0, 2'b01 << port});
    for (int k = 1; k <= 40 && rv_k < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        p_valid = 2'b00;
        p_we = 2'b00;
      end
      mem_ack = 1'b0;
      if (mem_req) begin
        saw = 1'b1;
        if (waitc == dly) begin
          chk({nm, "/mem_addr"}, {32'd0, mem_addr}, {32'd0, addr});
          chk({nm, "/mem_we"}, {63'd0, mem_we}, {63'd0, we});
          if (we) chk({nm, "/mem_wdata"}, {32'd0, mem_wdata}, {32'd0, wd});
          mem_rdata = memval(mem_addr);
          mem_ack = 1'b1;
        end
        waitc++;
      end
      if (r_valid) begin
        rv_k = k;
        chk({nm, "/r_id"}, {63'd0, r_id}, {63'd0, port});
        chk({nm, "/r_data"}, {32'd0, r_data}, {32'd0, exp_data});
      end
    end
    mem_ack = 1'b0;
    if (rv_k < 0) begin
      cmp++;
      errs++;
      $display("FAIL %s/timeout: got no r_valid expected r_valid", nm);
    end else begin
      chk({nm, "/latency"}, rv_k, exp_k);
      chk({nm, "/mem_traffic"}, {63'd0, saw}, {63'd0, exp_mem});
      @(negedge clk);
      chk({nm, "/r_pulse"}, {63'd0, r_valid}, 64'd0);
    end
  endtask

  task automatic apply_vec(input string nm, input vec_t v);
    if (v.we) m_mem[v.addr] = v.wdata;
    if (v.exp_hit) s_hit++;
    else s_miss++;
    txn(nm, v.port, v.we, v.addr, v.wdata, v.dly, v.exp_mem, v.exp_data);
  endtask

  task automatic chk_stats(input string nm);
`ifdef L2K_CTRL_STATS_EN
    chk({nm, "/hit_cnt"}, {32'd0, hit_cnt}, s_hit);
    chk({nm, "/miss_cnt"}, {32'd0, miss_cnt}, s_miss);
`else
    if (nm.len() < 0) $display("%s", nm);
`endif
  endtask

  initial begin
    int ng, nr;
    bit last_g, bad;
    logic [31:0] a, wd, ed;
    int idx, tg, dly;
    bit port, we, hit;

    rst = 1'b1;
    p_valid = 2'b00;
    p_we = 2'b00;
    p_addr = '0;
    p_wdata = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    m_mem[32'h100] = 32'hDEAD_BEEF;

    // port, we, addr, wdata, dly, exp_mem, exp_hit, exp_data
    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        1, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b0, 32'h100, 32'h0,        0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h100, 32'h1234_5678, 2, 1'b1, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h100, 32'h0,        0, 1'b0, 1'b1, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h200, 32'h0,        1, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[6] = '{1'b1, 1'b0, 32'h900, 32'h0,        0, 1'b1, 1'b0, 32'h5A5A_0900};
    vecs[7] = '{1'b0, 1'b0, 32'h100, 32'h0,        3, 1'b1, 1'b0, 32'h1234_5678};
    vecs[8] = '{1'b1, 1'b0, 32'h900, 32'h0,        0, 1'b1, 1'b0, 32'h5A5A_0900};
    vecs[9] = '{1'b0, 1'b0, 32'h900, 32'h0,        0, 1'b0, 1'b1, 32'h5A5A_0900};

    rst_dut();
    #1;
    chk("reset/r_valid", {63'd0, r_valid}, 64'd0);
    chk("reset/mem_req", {63'd0, mem_req}, 64'd0);
    chk("reset/mem_we", {63'd0, mem_we}, 64'd0);
    chk("reset/r_data", {32'd0, r_data}, 64'd0);
    chk("reset/p_ready", {62'd0, p_ready}, 64'd0);
    chk_stats("reset");

    for (int i = 0; i < 10; i++) begin
      apply_vec($sformatf("vec%0d", i), vecs[i]);
    end
    chk_stats("directed");

    // Both ports held valid: grants must alternate starting with fetch.
    rst_dut();
    ng = 0;
    nr = 0;
    last_g = 1'b0;
    @(negedge clk);
    p_we = 2'b00;
    p_addr = {32'h404, 32'h400};
    p_valid = 2'b11;
    for (int k = 0; k < 80 && nr < 4; k++) begin
      #1;
      if (p_ready != 2'b00 && ng < 4) begin
        chk($sformatf("arb/grant%0d", ng), {62'd0, p_ready}, (ng % 2 == 0) ? 64'd1 : 64'd2);
        last_g = p_ready[1];
        ng++;
      end
      if (r_valid) begin
        chk($sformatf("arb/r_id%0d", nr), {63'd0, r_id}, {63'd0, last_g});
        chk($sformatf("arb/r_data%0d", nr), {32'd0, r_data},
            {32'd0, memval(last_g ? 32'h404 : 32'h400)});
        nr++;
      end
      mem_ack = mem_req;
      mem_rdata = memval(mem_addr);
      @(negedge clk);
      if (ng == 4) p_valid = 2'b00;
    end
    mem_ack = 1'b0;
    p_valid = 2'b00;
    if (nr < 4) begin
      cmp++;
      errs++;
      $display("FAIL arb/timeout: got %0d responses expected 4", nr);
    end

    // Reset while a miss waits on memory.
    rst_dut();
    @(negedge clk);
    p_valid = 2'b01;
    p_addr = {32'h0, 32'h300};
    @(negedge clk);
    p_valid = 2'b00;
    @(negedge clk);
    chk("abort/mem_req_before", {63'd0, mem_req}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort/mem_req_after", {63'd0, mem_req}, 64'd0);
    rst = 1'b0;
    bad = r_valid;
    repeat (3) begin
      @(negedge clk);
      bad = bad | r_valid | mem_req;
    end
    chk("abort/quiet", {63'd0, bad}, 64'd0);
    s_miss = 1;
    txn("abort/reread", 1'b0, 1'b0, 32'h100, 32'h0, 1, 1'b1, 32'h1234_5678);
    chk_stats("abort");

    // Random traffic over a few aliasing lines against an abstract cache model.
    rst_dut();
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 3);
      tg = $urandom_range(0, 2);
      a = (tg << (IW + 2)) | (idx << 2);
      port = 1'($urandom_range(0, 1));
      we = port ? 1'($urandom_range(0, 1)) : 1'b0;
      wd = $urandom;
      dly = $urandom_range(0, 3);
      hit = mv.exists(idx) && mt[idx] == tg;
      if (hit) s_hit++;
      else s_miss++;
      if (we) begin
        ed = 32'h0;
        m_mem[a] = wd;
        if (hit) md[idx] = wd;
      end else if (hit) begin
        ed = md[idx];
      end else begin
        ed = memval(a);
        mv[idx] = 1'b1;
        mt[idx] = tg;
        md[idx] = ed;
      end
      txn($sformatf("rand%0d", n), port, we, a, wd, dly, we || !hit, ed);
    end
    chk_stats("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
